// File: rtl/sprite_renderer.sv
// sprite_renderer: per-sprite hit test, ROM addressing, animation and output stage.
// The sprite position is double buffered: pending registers are written at any time,
// and the active copy changes only at frame_start, so the sprite never tears mid-frame.
// Optional feature macro: SPRITE_TRANSP_EN makes pixels whose colour equals TRANSP_KEY
// transparent. Without it, sprite_on is purely geometric.
module sprite_renderer #(
  parameter int          SPR_W       = 256,
  parameter int          SPR_H       = 256,
  parameter int          SCALE_LOG2  = 0,
  parameter int          FRAMES      = 4,
  parameter int          FRAME_TICKS = 8,
  parameter int          ROM_LAT     = 1,
  parameter logic [11:0] TRANSP_KEY  = 12'h000,
  localparam int         FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int         RW          = $clog2(SPR_H),
  localparam int         CW          = $clog2(SPR_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [9:0]    y,
  input  logic          video_on,
  input  logic          frame_start,
  input  logic [10:0]   pos_x_in,
  input  logic [9:0]    pos_y_in,
  input  logic          en_in,
  input  logic          pos_wr,
  output logic [FW-1:0] rom_frame,
  output logic [RW-1:0] rom_row,
  output logic [CW-1:0] rom_col,
  input  logic [11:0]   rom_data,
  output logic [11:0]   rgb_out,
  output logic          sprite_on,
  output logic [FW-1:0] anim_frame
);

  localparam int          TW     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [11:0] SPAN_X = 12'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);
  localparam logic [TW-1:0] LAST_TICK = TW'(FRAME_TICKS - 1);

  typedef enum logic {IDLE, RUN} anim_state_t;

  logic [10:0]  pend_x;
  logic [9:0]   pend_y;
  logic         pend_en;
  logic [10:0]  ax;
  logic [9:0]   ay;
  logic         aen;

  logic [10:0]  next_x;
  logic [9:0]   next_y;
  logic         next_en;

  logic [11:0]  x_end;
  logic [10:0]  y_end;
  logic         hit;
  logic [10:0]  dx;
  logic [9:0]   dy;
  logic [10:0]  dx_s;
  logic [9:0]   dy_s;

  anim_state_t  state;
  logic [TW-1:0] tick;

  logic [ROM_LAT-1:0] hit_pipe;
  logic         hit_d;
  logic         visible;

  // Values the active registers take at frame_start; a same-cycle write bypasses pending.
  always_comb begin
    next_x  = pos_wr ? pos_x_in : pend_x;
    next_y  = pos_wr ? pos_y_in : pend_y;
    next_en = pos_wr ? en_in    : pend_en;
  end

  // Pending registers follow pos_wr; the active copy updates only at frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_x  <= '0;
      pend_y  <= '0;
      pend_en <= 1'b0;
      ax      <= '0;
      ay      <= '0;
      aen     <= 1'b0;
    end else begin
      if (pos_wr) begin
        pend_x  <= pos_x_in;
        pend_y  <= pos_y_in;
        pend_en <= en_in;
      end
      if (frame_start) begin
        ax  <= next_x;
        ay  <= next_y;
        aen <= next_en;
      end
    end
  end

  // Hit test with widened end coordinates so a sprite near the right/bottom edge clips instead of wrapping.
  always_comb begin
    x_end = {1'b0, ax} + SPAN_X;
    y_end = {1'b0, ay} + SPAN_Y;
    hit   = aen & video_on &
            (x >= ax) & ({1'b0, x} < x_end) &
            (y >= ay) & ({1'b0, y} < y_end);
  end

  // ROM address from the offset inside the sprite, divided down by the magnification.
  always_comb begin
    dx      = x - ax;
    dy      = y - ay;
    dx_s    = dx >> SCALE_LOG2;
    dy_s    = dy >> SCALE_LOG2;
    rom_col = dx_s[CW-1:0];
    rom_row = dy_s[RW-1:0];
  end

  assign rom_frame = anim_frame;

  // Animation FSM: state mirrors the active enable; it acts on the enable held before this frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      anim_frame <= '0;
    end else begin
      case (state)
        RUN: begin
          if (frame_start) begin
            if (tick == LAST_TICK) begin
              tick <= '0;
              if (FRAMES > 1)
                anim_frame <= anim_frame + 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: begin
          tick       <= tick;
          anim_frame <= anim_frame;
        end
      endcase
      if (frame_start)
        state <= next_en ? RUN : IDLE;
    end
  end

  // Delay hit so it lines up with the ROM data for the same pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_pipe <= '0;
    end else begin
      hit_pipe[0] <= hit;
      for (int i = 1; i < ROM_LAT; i++)
        hit_pipe[i] <= hit_pipe[i-1];
    end
  end

  assign hit_d = hit_pipe[ROM_LAT-1];

`ifdef SPRITE_TRANSP_EN
  assign visible = hit_d & (rom_data != TRANSP_KEY);
`else
  assign visible = hit_d;
`endif

  // Registered output stage towards the colour mux; colour is blanked wherever the sprite is not shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= '0;
      sprite_on <= 1'b0;
    end else begin
      rgb_out   <= visible ? rom_data : 12'h000;
      sprite_on <= visible;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: randomized and directed stimulus against a pixel-level reference model.
// The model keeps the sprite position, enable and animation counters as plain integers and
// predicts each pixel's colour from the geometry rules, then compares after the pipeline delay.
module tb_sprite_renderer;

  localparam int          SW  = 16;
  localparam int          SH  = 8;
  localparam int          SC  = 1;
  localparam int          NF  = 4;
  localparam int          FT  = 2;
  localparam int          RL  = 2;
  localparam logic [11:0] KEY = 12'h000;
  localparam int          SPX = SW << SC;
  localparam int          SPY = SH << SC;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_start;
  logic [10:0] pos_x_in;
  logic [9:0]  pos_y_in;
  logic        en_in;
  logic        pos_wr;
  logic [1:0]  rom_frame;
  logic [2:0]  rom_row;
  logic [3:0]  rom_col;
  logic [11:0] rom_data;
  logic [11:0] rgb_out;
  logic        sprite_on;
  logic [1:0]  anim_frame;

  int n_cmp = 0;
  int n_err = 0;

  int m_px, m_py, m_ax, m_ay, m_tick, m_anim;
  bit m_pen, m_aen;
  int q_rgb[$];
  int q_on[$];

  sprite_renderer #(
    .SPR_W(SW), .SPR_H(SH), .SCALE_LOG2(SC), .FRAMES(NF),
    .FRAME_TICKS(FT), .ROM_LAT(RL), .TRANSP_KEY(KEY)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .frame_start(frame_start), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .en_in(en_in), .pos_wr(pos_wr), .rom_frame(rom_frame), .rom_row(rom_row),
    .rom_col(rom_col), .rom_data(rom_data), .rgb_out(rgb_out),
    .sprite_on(sprite_on), .anim_frame(anim_frame)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: column 3 of every row holds the transparent colour.
  function automatic int romf(int f, int r, int c);
    int v;
    if (c == 3) return int'(KEY);
    v = ((f * 257) ^ (r * 73) ^ (c * 11) ^ 'h5A5) & 'hFFF;
    if (v == int'(KEY)) v = 1;
    return v;
  endfunction

  // Synchronous ROM with RL clocks of read latency.
  logic [11:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= 12'(romf(int'(rom_frame), int'(rom_row), int'(rom_col)));
    for (int i = 1; i < RL; i++)
      rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[RL-1];

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_pen = 0;
    m_ax = 0; m_ay = 0; m_aen = 0;
    m_tick = 0; m_anim = 0;
    q_rgb.delete();
    q_on.delete();
    for (int i = 0; i < RL; i++) begin
      q_rgb.push_back(0);
      q_on.push_back(0);
    end
  endtask

  // One pixel clock: drive inputs, check addressing, predict the pixel, advance model, check output.
  task automatic applyStimulus(input int xi, input int yi, input bit vo, input bit fs,
                               input bit pw, input int px, input int py, input bit pe);
    bit hit;
    int col, row, e_rgb, e_on;
    @(negedge clk);
    x           = 11'(xi);
    y           = 10'(yi);
    video_on    = vo;
    frame_start = fs;
    pos_wr      = pw;
    pos_x_in    = 11'(px);
    pos_y_in    = 10'(py);
    en_in       = pe;
    #1;
    hit = m_aen && vo && (xi >= m_ax) && (xi < m_ax + SPX) && (yi >= m_ay) && (yi < m_ay + SPY);
    col = ((xi - m_ax) / (1 << SC)) % SW;
    row = ((yi - m_ay) / (1 << SC)) % SH;
    checkOutput("anim_frame", int'(anim_frame), m_anim);
    checkOutput("rom_frame", int'(rom_frame), m_anim);
    if (hit) begin
      checkOutput("rom_col", int'(rom_col), col);
      checkOutput("rom_row", int'(rom_row), row);
    end
    e_rgb = hit ? romf(m_anim, row, col) : 0;
    e_on  = hit ? 1 : 0;
`ifdef SPRITE_TRANSP_EN
    if (e_rgb == int'(KEY)) begin
      e_on  = 0;
      e_rgb = 0;
    end
`endif
    q_rgb.push_back(e_rgb);
    q_on.push_back(e_on);
    if (m_aen && fs) begin
      if (m_tick == FT - 1) begin
        m_tick = 0;
        m_anim = (m_anim + 1) % NF;
      end else begin
        m_tick++;
      end
    end
    if (fs) begin
      m_ax  = pw ? px : m_px;
      m_ay  = pw ? py : m_py;
      m_aen = pw ? pe : m_pen;
    end
    if (pw) begin
      m_px = px; m_py = py; m_pen = pe;
    end
    @(posedge clk);
    #1;
    checkOutput("sprite_on", int'(sprite_on), q_on.pop_front());
    checkOutput("rgb_out", int'(rgb_out), q_rgb.pop_front());
  endtask

  task automatic scan_row(input int yi, input int x0, input int x1);
    for (int xx = x0; xx <= x1; xx++)
      applyStimulus(xx, yi, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic commit(input int px, input int py, input bit pe);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, px, py, pe);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int rx, ry, rpx, rpy;
    bit rfs, rpw, rpe, rvo;
    reset = 1'b1;
    x = '0; y = '0; video_on = 1'b0; frame_start = 1'b0;
    pos_x_in = '0; pos_y_in = '0; en_in = 1'b0; pos_wr = 1'b0;
    #3;
    checkOutput("reset_sprite_on", int'(sprite_on), 0);
    checkOutput("reset_rgb_out", int'(rgb_out), 0);
    checkOutput("reset_anim_frame", int'(anim_frame), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    $display("[TB] position commit and bypass");
    commit(100, 50, 1'b1);
    scan_row(50, 99, 133);
    scan_row(65, 98, 134);
    scan_row(66, 100, 104);
    scan_row(49, 100, 104);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 200, 60, 1'b1);
    scan_row(60, 198, 234);

    $display("[TB] mid-frame update and video_on gating");
    applyStimulus(210, 60, 1'b1, 1'b0, 1'b1, 300, 50, 1'b1);
    scan_row(60, 198, 234);
    scan_row(50, 298, 334);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    scan_row(50, 298, 334);
    for (int xx = 300; xx <= 310; xx++)
      applyStimulus(xx, 50, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] scaling at origin");
    commit(0, 0, 1'b1);
    scan_row(0, 0, 34);
    scan_row(15, 0, 34);

    $display("[TB] animation stepping");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(5, 5, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      scan_row(3, 4, 9);
    end

    $display("[TB] edge clipping and disable");
    commit(2040, 1020, 1'b1);
    scan_row(1020, 2030, 2047);
    scan_row(1023, 0, 10);
    scan_row(1023, 2040, 2047);
    commit(2040, 1020, 1'b0);
    scan_row(1020, 2035, 2047);

    $display("[TB] randomized traffic");
    commit(400, 200, 1'b1);
    for (int k = 0; k < 1500; k++) begin
      rfs = ($urandom_range(0, 19) == 0);
      rpw = ($urandom_range(0, 14) == 0);
      rpe = ($urandom_range(0, 4) != 0);
      rvo = ($urandom_range(0, 9) != 0);
      rpx = $urandom_range(0, 2047);
      rpy = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) begin
        rx = m_ax - 4 + $urandom_range(0, SPX + 8);
        ry = m_ay - 2 + $urandom_range(0, SPY + 4);
      end else begin
        rx = $urandom_range(0, 2047);
        ry = $urandom_range(0, 1023);
      end
      if (rx < 0) rx = 0;
      if (rx > 2047) rx = 2047;
      if (ry < 0) ry = 0;
      if (ry > 1023) ry = 1023;
      applyStimulus(rx, ry, rvo, rfs, rpw, rpx, rpy, rpe);
    end

    $display("[TB] reset mid-frame");
    commit(500, 100, 1'b1);
    scan_row(100, 500, 510);
    checkOutput("pre_reset_sprite_on", int'(sprite_on), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_sprite_on", int'(sprite_on), 0);
    checkOutput("async_reset_rgb_out", int'(rgb_out), 0);
    checkOutput("async_reset_anim_frame", int'(anim_frame), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    scan_row(100, 500, 510);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 500, 100, 1'b1);
    scan_row(100, 500, 510);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    scan_row(100, 498, 533);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised sprite renderer for the VGA pixel path. It compares the current scan coordinate against a double-buffered sprite position and generates ROM addresses, with optional integer scaling and multi-frame animation. It pipelines the ROM read and emits registered `rgb_out`/`sprite_on` to the pixel mux. It sits between `vga_sync` and the top-level colour mux, one instance per on-screen sprite.

## Interface
**Parameters**
- `SPR_W`, 256: sprite width in source pixels (power of two).
- `SPR_H`, 256: sprite height in source pixels (power of two).
- `SCALE_LOG2`, 0: on-screen magnification is 2^SCALE_LOG2. Legal values are 0 to 2.
- `FRAMES`, 4: number of animation frames in the ROM (power of two, ≥1).
- `FRAME_TICKS`, 8: display frames per animation step (≥1).
- `ROM_LAT`, 1: ROM read latency in clocks (≥1).
- `TRANSP_KEY`, 12'h000: colour treated as transparent.

**Ports**
- `clk`, input, 1: pixel clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `x`, input, 11: current pixel column from `vga_sync`.
- `y`, input, 10: current pixel row from `vga_sync`.
- `video_on`, input, 1: visible-area flag from `vga_sync`.
- `frame_start`, input, 1: one-clock pulse at the start of vertical blanking.
- `pos_x_in`, input, 11: pending sprite X.
- `pos_y_in`, input, 10: pending sprite Y.
- `en_in`, input, 1: pending sprite enable.
- `pos_wr`, input, 1: captures `pos_x_in`, `pos_y_in` and `en_in` into the pending registers.
- `rom_frame`, output, log2(FRAMES): animation frame index to the ROM.
- `rom_row`, output, log2(SPR_H): ROM row address.
- `rom_col`, output, log2(SPR_W): ROM column address.
- `rom_data`, input, 12: ROM colour, valid ROM_LAT clocks after the address.
- `rgb_out`, output, 12: sprite colour for the pixel.
- `sprite_on`, output, 1: sprite covers this pixel.
- `anim_frame`, output, log2(FRAMES): current animation frame.

## Operation
- **Double buffering:**
  - `pos_wr` loads the pending registers.
  - On `frame_start`, pending is copied into active `(ax, ay, aen)`.
  - If `pos_wr` and `frame_start` occur in the same cycle, active takes the new `*_in` values (bypass).
  - Active registers never change mid-frame.
- **Hit test (combinational):** `hit = aen & video_on & x≥ax & x<ax+(SPR_W<<SCALE_LOG2) & y≥ay & y<ay+(SPR_H<<SCALE_LOG2)`.
  - Sums are computed at 12 bits (X) and 11 bits (Y) and never wrap.
  - A sprite extending past 2047/1023 is clipped, not wrapped.
- **Addressing (combinational):**
  - `rom_col = (x−ax)>>SCALE_LOG2`, truncated to log2(SPR_W).
  - `rom_row = (y−ay)>>SCALE_LOG2`, truncated to log2(SPR_H).
  - `rom_frame = anim_frame`.
  - Address values are don't-care when `hit` is 0.
- **Pipeline:** `hit` is delayed through a ROM_LAT-stage shift register alongside the ROM read. The output stage then registers:
  - `rgb_out = hit_d ? rom_data : 0`.
  - `sprite_on = hit_d` (qualified by transparency, see Configuration).
- **Animation FSM:** two states, IDLE (`aen`=0) and RUN (`aen`=1).
  - In RUN, each `frame_start` increments `tick`.
  - When `tick` equals FRAME_TICKS−1, `tick` returns to 0 and `anim_frame` increments modulo FRAMES (wrap from FRAMES−1 to 0).
  - Entering IDLE holds both `tick` and `anim_frame`; they are not cleared.
  - The FSM evaluates `aen` before the `frame_start` copy in the same cycle, so the first tick counts one frame after enable.
  - If FRAMES is 1, `anim_frame` is constant 0.

## Timing
- Latency from `x`/`y` to `rgb_out`/`sprite_on` is exactly ROM_LAT+1 clocks. Upstream delays the sync signals by the same amount.
- Active position and enable become effective on the clock after `frame_start`.
- **Reset:** asynchronous, forces all of the following to 0 immediately:
  - active and pending registers, `tick`, `anim_frame`, the hit pipeline, `rgb_out`, `sprite_on`.
- **Reset released mid-frame:** the sprite stays invisible until a `pos_wr` followed by `frame_start`.

## Configuration
- `SPRITE_TRANSP_EN` defined: the output stage uses `sprite_on = hit_d & (rom_data != TRANSP_KEY)`, and `rgb_out` is forced to 0 wherever `sprite_on` is 0.
- `SPRITE_TRANSP_EN` undefined: `sprite_on` is purely geometric (`hit_d`), and `TRANSP_KEY` is ignored.

## Test plan
1. **Position commit and bypass (defaults).**
   - Stimulus: `pos_wr` with (100, 50, en=1), then `frame_start`. Scan x=99..356 on y=50.
   - Required: `sprite_on` is 1 for x=100..355 and 0 at 99 and 356, delayed by 2 clocks; `rom_col` steps 0..255.
   - Stimulus: `pos_wr` in the same cycle as `frame_start`.
   - Required: the new position is active on the next clock.
2. **No mid-frame update.**
   - Stimulus: `pos_wr` with (300, 50) mid-frame.
   - Required: the hit region stays at x=100..355 until the next `frame_start`.
3. **Scaling.**
   - Stimulus: SCALE_LOG2=1, ax=0.
   - Required: hit for x=0..511; `rom_col` = x>>1; x=1 gives col 0, x=511 gives col 255.
4. **Animation and edge clipping.**
   - Stimulus: FRAMES=4, FRAME_TICKS=2, 9 `frame_start` pulses with en=1.
   - Required: `anim_frame` sequence 0,0,1,1,2,2,3,3,0 (wrap).
   - Stimulus: ax=1900.
   - Required: hit for x=1900..2047 only, with no wrap to x=0.
5. **Transparency and disable (SPRITE_TRANSP_EN).**
   - Stimulus: `rom_data`=12'h000 inside the hit region.
   - Required: `sprite_on`=0, `rgb_out`=0. With the macro undefined, `sprite_on`=1.
   - Stimulus: `video_on`=0, or en=0 committed.
   - Required: `sprite_on`=0.
6. **Reset mid-frame.**
   - Stimulus: assert `reset` while `sprite_on`=1.
   - Required: all outputs are 0 within the same cycle (asynchronous).
   - Stimulus: release `reset`.
   - Required: the sprite stays off until a `pos_wr` followed by `frame_start`.
